// File: rtl/dm_access_arbiter_if.sv
// Requester-A / requester-B / data-memory signal bundle for dm_access_arbiter.
// slave  : arbiter side (drives grants, completions and the DM bus).
// master : environment side (requesters and the DM model).
interface dm_access_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    // Requester A (core load/store port)
    logic          ReqA;
    logic          WrA;
    logic [2:0]    CtrlA;
    logic [AW-1:0] AddrA;
    logic [DW-1:0] WDataA;
    logic          GntA;
    logic          DoneA;
    logic [DW-1:0] RDataA;

    // Requester B (program/data loader port)
    logic          ReqB;
    logic          WrB;
    logic [2:0]    CtrlB;
    logic [AW-1:0] AddrB;
    logic [DW-1:0] WDataB;
    logic          GntB;
    logic          DoneB;
    logic [DW-1:0] RDataB;

    // Status
    logic          Err;
    logic          Busy;

    // Data memory side
    logic [AW-1:0] Address;
    logic [DW-1:0] DataWr;
    logic [2:0]    DMCtrl;
    logic          DMWr;
    logic [DW-1:0] DataRd;

    modport slave (
        input  ReqA, WrA, CtrlA, AddrA, WDataA,
        output GntA, DoneA, RDataA,
        input  ReqB, WrB, CtrlB, AddrB, WDataB,
        output GntB, DoneB, RDataB,
        output Err, Busy,
        output Address, DataWr, DMCtrl, DMWr,
        input  DataRd
    );

    modport master (
        output ReqA, WrA, CtrlA, AddrA, WDataA,
        input  GntA, DoneA, RDataA,
        output ReqB, WrB, CtrlB, AddrB, WDataB,
        input  GntB, DoneB, RDataB,
        input  Err, Busy,
        input  Address, DataWr, DMCtrl, DMWr,
        output DataRd
    );
endinterface

// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter: shares the data memory between requester A (core) and
// requester B (loader). One access at a time, 3 cycles each:
//   SETUP  (Gnt pulse, DM address/data/ctrl latched)
//   ACCESS (single DMWr pulse for stores)
//   DONE   (Done pulse, load data returned in RData)
// Optional build macro DM_ALIGN_CHECK_EN: flag illegal DMCtrl codes and
// misaligned halfword/word accesses; such accesses never write DM and return
// RData=0 with Err=1.
module dm_access_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic               clk,
    input  logic               rst,
    dm_access_arbiter_if.slave bus
);

    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    logic   owner;       // 0 = A, 1 = B for the access in flight
    logic   last_owner;  // owner of the most recent grant
    logic   wr_q;        // access in flight is a store
    logic   fault_q;     // access in flight failed the alignment check

    logic          any_req_c;
    logic          pick_b_c;
    logic          win_wr_c;
    logic [CW-1:0] win_ctrl_c;
    logic [AW-1:0] win_addr_c;
    logic [DW-1:0] win_wdata_c;
    logic          win_fault_c;

`ifdef DM_ALIGN_CHECK_EN
    // Illegal code, odd halfword or non-word-aligned word access.
    function automatic logic access_fault(input logic [CW-1:0] ctrl,
                                          input logic [1:0]    alow);
        logic f;
        case (ctrl)
            3'b000, 3'b100: f = 1'b0;
            3'b001, 3'b101: f = alow[0];
            3'b010:         f = (alow != 2'b00);
            default:        f = 1'b1;
        endcase
        return f;
    endfunction
`endif

    // Arbitration: lone requester wins; on contention A wins under fixed
    // priority, otherwise whoever was not the last owner.
    always_comb begin
        any_req_c = bus.ReqA | bus.ReqB;
        pick_b_c  = 1'b0;
        if (bus.ReqB) begin
            if (!bus.ReqA)
                pick_b_c = 1'b1;
            else if ((FIXED_PRIO == 0) && (last_owner == 1'b0))
                pick_b_c = 1'b1;
        end
    end

    // Winner's access fields.
    always_comb begin
        win_wr_c    = pick_b_c ? bus.WrB    : bus.WrA;
        win_ctrl_c  = pick_b_c ? bus.CtrlB  : bus.CtrlA;
        win_addr_c  = pick_b_c ? bus.AddrB  : bus.AddrA;
        win_wdata_c = pick_b_c ? bus.WDataB : bus.WDataA;
`ifdef DM_ALIGN_CHECK_EN
        win_fault_c = access_fault(win_ctrl_c, win_addr_c[1:0]);
`else
        win_fault_c = 1'b0;
`endif
    end

    // Sequencer with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_owner  <= 1'b1;
            wr_q        <= 1'b0;
            fault_q     <= 1'b0;
            bus.GntA    <= 1'b0;
            bus.GntB    <= 1'b0;
            bus.DoneA   <= 1'b0;
            bus.DoneB   <= 1'b0;
            bus.RDataA  <= '0;
            bus.RDataB  <= '0;
            bus.Err     <= 1'b0;
            bus.Busy    <= 1'b0;
            bus.Address <= '0;
            bus.DataWr  <= '0;
            bus.DMCtrl  <= '0;
            bus.DMWr    <= 1'b0;
        end else begin
            bus.GntA  <= 1'b0;
            bus.GntB  <= 1'b0;
            bus.DoneA <= 1'b0;
            bus.DoneB <= 1'b0;
            bus.DMWr  <= 1'b0;
            bus.Err   <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (any_req_c) begin
                        state       <= SETUP;
                        owner       <= pick_b_c;
                        last_owner  <= pick_b_c;
                        wr_q        <= win_wr_c;
                        fault_q     <= win_fault_c;
                        bus.Address <= win_addr_c;
                        bus.DataWr  <= win_wdata_c;
                        bus.DMCtrl  <= win_ctrl_c;
                        bus.GntA    <= ~pick_b_c;
                        bus.GntB    <= pick_b_c;
                        bus.Busy    <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        bus.Busy <= 1'b0;
                    end
                end

                SETUP: begin
                    state    <= ACCESS;
                    bus.DMWr <= wr_q & ~fault_q;
                end

                ACCESS: begin
                    state   <= DONE;
                    bus.Err <= fault_q;
                    if (owner == 1'b0) begin
                        bus.DoneA <= 1'b1;
                        if (fault_q)
                            bus.RDataA <= '0;
                        else if (!wr_q)
                            bus.RDataA <= bus.DataRd;
                    end else begin
                        bus.DoneB <= 1'b1;
                        if (fault_q)
                            bus.RDataB <= '0;
                        else if (!wr_q)
                            bus.RDataB <= bus.DataRd;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed bench for dm_access_arbiter: one instance with round-robin
// arbitration backed by a small word memory, one with fixed priority.
module tb_dm_access_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dm_access_arbiter_if #(.AW(32), .DW(32)) ifc0 ();
    dm_access_arbiter_if #(.AW(32), .DW(32)) ifc1 ();

    dm_access_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (ifc0.slave)
    );

    dm_access_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (ifc1.slave)
    );

    // Word memory behind dut0: combinational read, write on DMWr.
    logic [31:0] mem [16];
    assign ifc0.DataRd = mem[ifc0.Address[5:2]];
    always @(posedge clk) begin
        if (ifc0.DMWr)
            mem[ifc0.Address[5:2]] <= ifc0.DataWr;
    end
    assign ifc1.DataRd = 32'h0000_0000;

    int vectors = 0;
    int errors  = 0;

    task automatic set_a(input logic req, input logic wr, input logic [2:0] ctrl,
                         input logic [31:0] addr, input logic [31:0] wdata);
        ifc0.ReqA = req; ifc0.WrA = wr; ifc0.CtrlA = ctrl;
        ifc0.AddrA = addr; ifc0.WDataA = wdata;
    endtask

    task automatic set_b(input logic req, input logic wr, input logic [2:0] ctrl,
                         input logic [31:0] addr, input logic [31:0] wdata);
        ifc0.ReqB = req; ifc0.WrB = wr; ifc0.CtrlB = ctrl;
        ifc0.AddrB = addr; ifc0.WDataB = wdata;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        set_a(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        set_b(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        ifc1.ReqA = 1'b0; ifc1.ReqB = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ifc0.GntA, ifc0.GntB, ifc0.DoneA, ifc0.DoneB, ifc0.Err, ifc0.Busy, ifc0.DMWr} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {ifc0.GntA, ifc0.GntB, ifc0.DoneA, ifc0.DoneB, ifc0.Err, ifc0.Busy, ifc0.DMWr});
        end
        vectors++;
        if ({ifc0.Address, ifc0.DataWr, ifc0.DMCtrl, ifc0.RDataA, ifc0.RDataB} !== '0) begin
            errors++;
            $display("FAIL reset_bus: addr %h data %h ctrl %b ra %h rb %h expected all zero",
                     ifc0.Address, ifc0.DataWr, ifc0.DMCtrl, ifc0.RDataA, ifc0.RDataB);
        end
        vectors++;
        if (ifc1.Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_fp: got %b expected 0", ifc1.Busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_store_a();
        apply_reset();
        set_a(1'b1, 1'b1, 3'b010, 32'd8, 32'h001F_FC0F);
        @(negedge clk); // SETUP
        vectors++;
        if ({ifc0.GntA, ifc0.GntB, ifc0.DMWr, ifc0.Busy} !== 4'b1001) begin
            errors++;
            $display("FAIL store_setup_flags: gntA,gntB,dmwr,busy got %b expected 1001",
                     {ifc0.GntA, ifc0.GntB, ifc0.DMWr, ifc0.Busy});
        end
        vectors++;
        if (ifc0.Address !== 32'd8 || ifc0.DataWr !== 32'h001F_FC0F || ifc0.DMCtrl !== 3'b010) begin
            errors++;
            $display("FAIL store_setup_bus: addr %h data %h ctrl %b expected 8 001ffc0f 010",
                     ifc0.Address, ifc0.DataWr, ifc0.DMCtrl);
        end
        set_a(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk); // ACCESS
        vectors++;
        if (ifc0.DMWr !== 1'b1 || ifc0.GntA !== 1'b0 || ifc0.Address !== 32'd8) begin
            errors++;
            $display("FAIL store_access: dmwr %b gntA %b addr %h expected 1 0 8",
                     ifc0.DMWr, ifc0.GntA, ifc0.Address);
        end
        @(negedge clk); // DONE
        vectors++;
        if ({ifc0.DoneA, ifc0.DoneB, ifc0.Err, ifc0.DMWr} !== 4'b1000 || ifc0.Address !== 32'd8) begin
            errors++;
            $display("FAIL store_done: doneA,doneB,err,dmwr %b addr %h expected 1000 8",
                     {ifc0.DoneA, ifc0.DoneB, ifc0.Err, ifc0.DMWr}, ifc0.Address);
        end
        vectors++;
        if (ifc0.RDataA !== 32'h0) begin
            errors++;
            $display("FAIL store_rdata: got %h expected 00000000", ifc0.RDataA);
        end
        @(negedge clk); // back in IDLE
        vectors++;
        if (ifc0.Busy !== 1'b0 || ifc0.DoneA !== 1'b0 || ifc0.Address !== 32'd8) begin
            errors++;
            $display("FAIL store_idle: busy %b doneA %b addr %h expected 0 0 8",
                     ifc0.Busy, ifc0.DoneA, ifc0.Address);
        end
        vectors++;
        if (mem[2] !== 32'h001F_FC0F) begin
            errors++;
            $display("FAIL store_mem: got %h expected 001ffc0f", mem[2]);
        end
    endtask

    task automatic test_load_a();
        set_a(1'b1, 1'b0, 3'b010, 32'd8, 32'h0);
        @(negedge clk);
        vectors++;
        if (ifc0.GntA !== 1'b1) begin
            errors++;
            $display("FAIL load_gnt: got %b expected 1", ifc0.GntA);
        end
        set_a(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        vectors++;
        if (ifc0.DMWr !== 1'b0) begin
            errors++;
            $display("FAIL load_dmwr: got %b expected 0", ifc0.DMWr);
        end
        @(negedge clk);
        vectors++;
        if (ifc0.DoneA !== 1'b1 || ifc0.RDataA !== 32'h001F_FC0F) begin
            errors++;
            $display("FAIL load_done: doneA %b rdataA %h expected 1 001ffc0f", ifc0.DoneA, ifc0.RDataA);
        end
        vectors++;
        if (ifc0.DoneB !== 1'b0 || ifc0.RDataB !== 32'h0) begin
            errors++;
            $display("FAIL load_nonowner: doneB %b rdataB %h expected 0 00000000", ifc0.DoneB, ifc0.RDataB);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic exp_b;
        apply_reset();
        set_a(1'b1, 1'b0, 3'b010, 32'd8, 32'h0);
        set_b(1'b1, 1'b0, 3'b010, 32'd8, 32'h0);
        for (int cyc = 1; cyc <= 13; cyc++) begin
            @(negedge clk);
            exp_b = (((cyc - 1) / 3) % 2) == 1;
            if (cyc <= 12) begin
                vectors++;
                if (ifc0.Busy !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_busy c%0d: got %b expected 1", cyc, ifc0.Busy);
                end
            end
            if (cyc % 3 == 1 && cyc <= 10) begin
                vectors++;
                if (ifc0.GntA !== !exp_b || ifc0.GntB !== exp_b) begin
                    errors++;
                    $display("FAIL rr_gnt c%0d: gntA %b gntB %b expected %b %b",
                             cyc, ifc0.GntA, ifc0.GntB, !exp_b, exp_b);
                end
            end else begin
                vectors++;
                if (ifc0.GntA !== 1'b0 || ifc0.GntB !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_nognt c%0d: gntA %b gntB %b expected 0 0", cyc, ifc0.GntA, ifc0.GntB);
                end
            end
            if (cyc % 3 == 0) begin
                vectors++;
                if (ifc0.DoneA !== !exp_b || ifc0.DoneB !== exp_b) begin
                    errors++;
                    $display("FAIL rr_done c%0d: doneA %b doneB %b expected %b %b",
                             cyc, ifc0.DoneA, ifc0.DoneB, !exp_b, exp_b);
                end
            end
            if (cyc == 10) begin
                ifc0.ReqA = 1'b0;
                ifc0.ReqB = 1'b0;
            end
            if (cyc == 13) begin
                vectors++;
                if (ifc0.Busy !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_idle: busy %b expected 0", ifc0.Busy);
                end
            end
        end
    endtask

    task automatic test_fixed_prio();
        logic exp_b;
        apply_reset();
        ifc1.WrA = 1'b0; ifc1.CtrlA = 3'b010; ifc1.AddrA = 32'd4; ifc1.WDataA = 32'h0;
        ifc1.WrB = 1'b0; ifc1.CtrlB = 3'b010; ifc1.AddrB = 32'd16; ifc1.WDataB = 32'h0;
        ifc1.ReqA = 1'b1;
        ifc1.ReqB = 1'b1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            exp_b = ((cyc - 1) / 3) >= 4;
            if (cyc <= 15) begin
                vectors++;
                if (ifc1.Busy !== 1'b1) begin
                    errors++;
                    $display("FAIL fp_busy c%0d: got %b expected 1", cyc, ifc1.Busy);
                end
            end
            if (cyc % 3 == 1 && cyc <= 13) begin
                vectors++;
                if (ifc1.GntA !== !exp_b || ifc1.GntB !== exp_b) begin
                    errors++;
                    $display("FAIL fp_gnt c%0d: gntA %b gntB %b expected %b %b",
                             cyc, ifc1.GntA, ifc1.GntB, !exp_b, exp_b);
                end
            end
            if (cyc % 3 == 0) begin
                vectors++;
                if (ifc1.DoneA !== !exp_b || ifc1.DoneB !== exp_b) begin
                    errors++;
                    $display("FAIL fp_done c%0d: doneA %b doneB %b expected %b %b",
                             cyc, ifc1.DoneA, ifc1.DoneB, !exp_b, exp_b);
                end
            end
            if (cyc == 10) ifc1.ReqA = 1'b0;
            if (cyc == 13) ifc1.ReqB = 1'b0;
            if (cyc == 16) begin
                vectors++;
                if (ifc1.Busy !== 1'b0) begin
                    errors++;
                    $display("FAIL fp_idle: busy %b expected 0", ifc1.Busy);
                end
            end
        end
    endtask

    task automatic test_reset_in_access();
        apply_reset();
        mem[3] = 32'h0000_0000;
        set_a(1'b1, 1'b1, 3'b010, 32'd12, 32'hCAFE_F00D);
        @(negedge clk);
        set_a(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        vectors++;
        if (ifc0.DMWr !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_dmwr: got %b expected 1", ifc0.DMWr);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({ifc0.DMWr, ifc0.Busy, ifc0.GntA, ifc0.DoneA} !== 4'b0000 ||
            ifc0.Address !== 32'h0 || ifc0.DataWr !== 32'h0 || ifc0.DMCtrl !== 3'b000) begin
            errors++;
            $display("FAIL rst_async: dmwr,busy,gntA,doneA %b addr %h data %h ctrl %b expected 0000 0 0 0",
                     {ifc0.DMWr, ifc0.Busy, ifc0.GntA, ifc0.DoneA}, ifc0.Address, ifc0.DataWr, ifc0.DMCtrl);
        end
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (mem[3] !== 32'h0) begin
            errors++;
            $display("FAIL rst_mem: got %h expected 00000000", mem[3]);
        end
        set_b(1'b1, 1'b0, 3'b010, 32'd12, 32'h0);
        @(negedge clk);
        vectors++;
        if (ifc0.GntB !== 1'b1 || ifc0.GntA !== 1'b0) begin
            errors++;
            $display("FAIL rst_regrant: gntA %b gntB %b expected 0 1", ifc0.GntA, ifc0.GntB);
        end
        set_b(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (ifc0.DoneB !== 1'b1 || ifc0.DoneA !== 1'b0) begin
            errors++;
            $display("FAIL rst_done: doneA %b doneB %b expected 0 1", ifc0.DoneA, ifc0.DoneB);
        end
        @(negedge clk);
    endtask

    task automatic test_align();
        logic        exp_dmwr;
        logic        exp_err;
        logic [31:0] exp_rb;
`ifdef DM_ALIGN_CHECK_EN
        exp_dmwr = 1'b0; exp_err = 1'b1; exp_rb = 32'h0;
`else
        exp_dmwr = 1'b1; exp_err = 1'b0; exp_rb = 32'h001F_FC0F;
`endif
        apply_reset();
        set_b(1'b1, 1'b0, 3'b010, 32'd8, 32'h0);
        @(negedge clk);
        set_b(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (ifc0.DoneB !== 1'b1 || ifc0.RDataB !== 32'h001F_FC0F || ifc0.Err !== 1'b0) begin
            errors++;
            $display("FAIL align_preload: doneB %b rdataB %h err %b expected 1 001ffc0f 0",
                     ifc0.DoneB, ifc0.RDataB, ifc0.Err);
        end
        set_b(1'b1, 1'b1, 3'b010, 32'd6, 32'hDEAD_BEEF);
        @(negedge clk);
        vectors++;
        if (ifc0.GntB !== 1'b1 || ifc0.Address !== 32'd6) begin
            errors++;
            $display("FAIL align_gnt: gntB %b addr %h expected 1 6", ifc0.GntB, ifc0.Address);
        end
        set_b(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        vectors++;
        if (ifc0.DMWr !== exp_dmwr || ifc0.Address !== 32'd6) begin
            errors++;
            $display("FAIL align_dmwr: dmwr %b addr %h expected %b 6", ifc0.DMWr, ifc0.Address, exp_dmwr);
        end
        @(negedge clk);
        vectors++;
        if (ifc0.DoneB !== 1'b1 || ifc0.Err !== exp_err || ifc0.RDataB !== exp_rb) begin
            errors++;
            $display("FAIL align_done: doneB %b err %b rdataB %h expected 1 %b %h",
                     ifc0.DoneB, ifc0.Err, ifc0.RDataB, exp_err, exp_rb);
        end
        @(negedge clk);
        vectors++;
        if (ifc0.Err !== 1'b0) begin
            errors++;
            $display("FAIL align_err_clear: got %b expected 0", ifc0.Err);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        set_a(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        set_b(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        ifc1.ReqA = 1'b0; ifc1.WrA = 1'b0; ifc1.CtrlA = 3'b000; ifc1.AddrA = 32'h0; ifc1.WDataA = 32'h0;
        ifc1.ReqB = 1'b0; ifc1.WrB = 1'b0; ifc1.CtrlB = 3'b000; ifc1.AddrB = 32'h0; ifc1.WDataB = 32'h0;

        test_reset();
        test_store_a();
        test_load_a();
        test_back_to_back();
        test_fixed_prio();
        test_reset_in_access();
        test_align();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
